x_burst_gen: RTL
================

// Module: x_burst_gen
// PURPOSE
//  Stimulus transmitter for the start/x/g counting controller: drives the
//  controller's start line s and count-enable stream x, then waits for its g.
//  On a go request it holds s low (controller clear) for one cycle and raises s.
//  It then drives x high for exactly LEN cycles and waits up to TIMEOUT cycles
//  for g, reporting done or err. Sits at the initiator end of the s/x/g interface.
// PARAMETERS
//  CNT_W    4   width of burst-length counter; LEN=0 encodes 2**CNT_W cycles
//  TIMEOUT  8   max cycles in WAIT before err; legal range 1..255 (8-bit timer)
// PORTS
//  clk    in   1      system clock, all state updates on posedge
//  reset  in   1      asynchronous, active-low reset
//  go     in   1      start request, sampled in IDLE only
//  len    in   CNT_W  burst length, latched on the go cycle
//  g      in   1      completion flag from the counting controller
//  s      out  1      controller start/clear line; low = controller held clear
//  x      out  1      count-enable stream to the controller
//  busy   out  1      high in every state except IDLE
//  done   out  1      one-cycle pulse: g seen within TIMEOUT
//  err    out  1      one-cycle pulse: TIMEOUT expired without g
// BEHAVIOUR
//  One clock; reset is asynchronous and active-low.
//  Reset (reset=0): state=IDLE, counters=0, s=0, x=0, busy=0, done=0, err=0.
//  All outputs are registered (Moore) and change one cycle after state entry.
//  States and transitions:
//   IDLE : s=0 x=0. go=1 -> CLR and len_q<=len. go=0 -> stay.
//   CLR  : s=0 x=0 for exactly 1 cycle -> ARM.
//   ARM  : s=1 x=0 for 1 cycle, so the controller leaves its init state -> BURST.
//          On entry, cnt<=(len_q==0 ? 2**CNT_W : len_q).
//   BURST: s=1 x=1. cnt decrements each cycle. At cnt==1 -> WAIT.
//          x is high for exactly cnt-initial cycles.
//   WAIT : s=1 x=0. tmr counts up from 0.
//          g=1 -> DONE (g beats timeout if both happen in the same cycle).
//          tmr==TIMEOUT-1 and g=0 -> FAIL.
//   DONE : done=1 for 1 cycle, s=1 -> IDLE.
//   FAIL : err=1 for 1 cycle, s=1 -> IDLE.
//  go is ignored while busy; no queuing.
//  g outside WAIT is ignored. This includes a g that arrives during BURST.
//  done and err are mutually exclusive.
//  Returning to IDLE drops s, which clears the controller for the next burst.
//  Reset asserted mid-operation: immediate return to IDLE values, s=0, x=0.
//   No done/err pulse on reset; the partial burst is abandoned.
//  len changes after the go cycle have no effect on the current burst.
//  Arithmetic: cnt is CNT_W+1 bits wide to hold 2**CNT_W. tmr is 8 bits.
//   Neither counter wraps: both are reloaded or cleared on state entry.
// STRUCTURE
//  Shared package/include: state encodings IDLE,CLR,ARM,BURST,WAIT,DONE,FAIL
//   (3-bit localparams) and CNT_W default, shared with the controller bench.
//  Sub-module: load_down_counter.
//   Ports: clk, reset, load, en, din, q, one.
//   Async active-low clear; holds the burst count.
//  The FSM, the WAIT timer and the output registers live in x_burst_gen.
// TESTING
//  1 reset=0 mid-BURST (len=8, after 3 x cycles) -> s=0 x=0 busy=0 next edge;
//    no done/err pulse.
//  2 go with len=5, g tied to 1 -> s low 1 cycle, s high, x high 5 cycles,
//    done pulse 1 cycle after WAIT entry. Total go-to-done = 9 cycles.
//  3 go with len=0 -> x high exactly 16 cycles.
//    Loop back through the real counting controller: g rises and done pulses.
//  4 go with len=3, g held 0 -> err pulses TIMEOUT=8 cycles after WAIT entry,
//    done stays 0, back to IDLE with s=0.
//  5 g=1 during BURST and go=1 while busy -> both ignored. The burst length is
//    unchanged, and the second go starts no new transfer.
//  6 g rises on the last WAIT cycle (tmr=7) -> done=1, err=0.

Source files
------------

// File: rtl/x_burst_gen_pkg.sv
// Shared definitions for the s/x/g burst transmitter and its controller bench:
// 3-bit state encodings and the default burst-counter width.
package x_burst_gen_pkg;

    localparam int CNT_W_DEF = 4;

    localparam logic [2:0] ENC_IDLE  = 3'd0;
    localparam logic [2:0] ENC_CLR   = 3'd1;
    localparam logic [2:0] ENC_ARM   = 3'd2;
    localparam logic [2:0] ENC_BURST = 3'd3;
    localparam logic [2:0] ENC_WAIT  = 3'd4;
    localparam logic [2:0] ENC_DONE  = 3'd5;
    localparam logic [2:0] ENC_FAIL  = 3'd6;

    typedef enum logic [2:0] {
        IDLE  = ENC_IDLE,
        CLR   = ENC_CLR,
        ARM   = ENC_ARM,
        BURST = ENC_BURST,
        WAIT  = ENC_WAIT,
        DONE  = ENC_DONE,
        FAIL  = ENC_FAIL
    } state_t;

endpackage

// File: rtl/x_burst_gen_if.sv
// Request/status and s/x/g signals between the burst transmitter (master)
// and whoever requests bursts and hosts the counting controller (slave).
interface x_burst_gen_if #(
    parameter int CNT_W = x_burst_gen_pkg::CNT_W_DEF
) ();

    logic             go;
    logic [CNT_W-1:0] len;
    logic             g;
    logic             s;
    logic             x;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        input  go, len, g,
        output s, x, busy, done, err
    );

    modport slave (
        output go, len, g,
        input  s, x, busy, done, err
    );

endinterface

// File: rtl/x_burst_gen_load_down_counter.sv
// Loadable down counter holding the remaining burst length; flags when the
// count has reached one so the owner can leave the burst on that cycle.
module load_down_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] q,
    output logic         one
);

    // Load takes priority over decrement; the count never wraps below zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (en && (q != '0)) begin
            q <= q - W'(1);
        end
    end

    assign one = (q == W'(1));

endmodule

// File: rtl/x_burst_gen.sv
// Burst transmitter: clears the counting controller via s, streams x for the
// latched length, then waits a bounded time for g and pulses done or err.
module x_burst_gen
    import x_burst_gen_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = 8
) (
    input logic            clk,
    input logic            reset,
    x_burst_gen_if.master  bus
);

    localparam logic [CNT_W:0] FULL_COUNT = {1'b1, {CNT_W{1'b0}}};
    localparam logic [7:0]     TMR_LAST   = 8'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic [7:0]       tmr;
    logic [CNT_W:0]   cnt_q;
    logic [CNT_W:0]   cnt_din;
    logic             cnt_one;
    logic             s_q;
    logic             x_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    assign cnt_din = (len_q == '0) ? FULL_COUNT : {1'b0, len_q};

    load_down_counter #(.W(CNT_W + 1)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (state == CLR),
        .en    (state == BURST),
        .din   (cnt_din),
        .q     (cnt_q),
        .one   (cnt_one)
    );

    // Sequencer: latch len on go, clear, arm, burst, then bounded wait for g.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            len_q <= '0;
            tmr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        state <= CLR;
                        len_q <= bus.len;
                    end
                end
                CLR:   state <= ARM;
                ARM:   state <= BURST;
                BURST: begin
                    if (cnt_one || (cnt_q == '0)) begin
                        state <= WAIT;
                        tmr   <= '0;
                    end
                end
                WAIT: begin
                    if (bus.g) begin
                        state <= DONE;
                    end else if (tmr == TMR_LAST) begin
                        state <= FAIL;
                    end else begin
                        tmr <= tmr + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                FAIL:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are a registered decode of the state, so they trail it by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_q    <= 1'b0;
            x_q    <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            s_q    <= (state inside {ARM, BURST, WAIT, DONE, FAIL});
            x_q    <= (state == BURST);
            busy_q <= (state != IDLE);
            done_q <= (state == DONE);
            err_q  <= (state == FAIL);
        end
    end

    assign bus.s    = s_q;
    assign bus.x    = x_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;

endmodule
